// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned, with annul.
// Optional div_zero_o flag port is built only when DIV_ZERO_FLAG_EN is defined.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic               div_zero_o,
`endif
  output logic [1:0]         dbg_state_o
);

  // Handshake: start_i is a level request held until ready_o is seen; ready_o
  // stays high with result_o stable until start_i drops, and annul_i aborts
  // any non-idle state without a ready_o pulse.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH+1:0]   shifted, diff;
  logic [WIDTH:0]     rem_step, rem_fix;
  logic [WIDTH-1:0]   quot_step, quot_fix;
  logic               last_iter;
  logic               ready_d, busy_d;

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    // quot_q doubles as the dividend shift register: its MSB feeds the trial
    // subtraction while the new quotient bit enters at the LSB.
    shifted   = {rem_q, quot_q[WIDTH-1]};
    diff      = shifted - {2'b00, dvs_q};
    rem_step  = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    quot_step = {quot_q[WIDTH-2:0], ~diff[WIDTH+1]};
    quot_fix  = neg_quot_q ? -quot_step : quot_step;
    rem_fix   = neg_rem_q ? -rem_step : rem_step;
    last_iter = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i && !annul_i)
                  state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON:     state_d = annul_i ? S_IDLE : (last_iter ? S_END : S_ON);
      S_END:    state_d = (annul_i || !start_i) ? S_IDLE : S_END;
      default:  state_d = S_IDLE;
    endcase

    // Outputs lag the state by one edge so an abort never shows a result.
    ready_d = (state_q == S_END) && (state_d == S_END);
    busy_d  = ((state_q == S_BYZERO) || (state_q == S_ON)) && (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      result_q <= ready_d ? {rem_q[WIDTH-1:0], quot_q} : '0;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_ON) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= mag1;
            dvs_q      <= mag2;
            neg_quot_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i && opdata1_i[WIDTH-1];
          end else if (state_d == S_BYZERO) begin
            // Divide by zero reports the raw dividend, no sign handling.
            cnt_q      <= '0;
            rem_q      <= {1'b0, opdata1_i};
            quot_q     <= '1;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
          end
        end
        S_ON: begin
          if (state_d != S_IDLE) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
              quot_q <= quot_fix;
              rem_q  <= rem_fix;
            end else begin
              quot_q <= quot_step;
              rem_q  <= rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (rst)
      dz_q <= 1'b0;
    else if (state_d == S_IDLE)
      dz_q <= 1'b0;
    else if ((state_q == S_IDLE) && (state_d == S_BYZERO))
      dz_q <= 1'b1;
  end

  assign div_zero_o = dz_q;
`endif

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative divider for the execute stage, generalising the single-cycle ALU/multiply path to a multi-cycle signed/unsigned DIV/DIVU unit of configurable width. The execute stage launches a division with a level start request, stalls the pipeline while the divider is busy, and writes the packed {remainder, quotient} result to HI/LO once ready is signalled. Radix-2 restoring algorithm, one quotient bit per cycle, with annul support for pipeline flushes.

## Interface
- WIDTH, 32, operand width in bits (≥ 4); result is 2*WIDTH bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high (`RstEnable`).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  WIDTH  dividend; sampled with start.
- opdata2_i  input  WIDTH  divisor; sampled with start.
- start_i  input  1  level request; held high by execute stage until ready_o seen.
- annul_i  input  1  abort current division (flush); effective in every non-IDLE state.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; valid while ready_o = 1, else 0.
- ready_o  output  1  result valid.
- busy_o  output  1  division in progress (stall request to control).
- div_zero_o  output  1  divisor was zero; valid with ready_o (present only with DIV_ZERO_FLAG_EN).

## Operation
- States: IDLE, BYZERO, ON, END. Registered state, counter (clog2(WIDTH)+1 bits), partial remainder (WIDTH+1 bits), quotient shift register, captured sign bits.
- IDLE: start_i=1 & annul_i=0 → capture operands; divisor==0 → BYZERO, else → ON with counter=0. Signed mode: negative operands replaced by two's-complement magnitude; dividend and divisor signs stored.
- ON: each cycle trial-subtract divisor magnitude from {partial remainder, next dividend bit}; non-negative → keep difference, shift in quotient bit 1; else keep, shift in 0. Counter increments; after the WIDTH-th iteration → END.
- Sign fix-up on ON→END: signed & signs differ → quotient negated; signed & dividend negative → remainder negated. Unsigned: no fix-up.
- BYZERO: next cycle → END with quotient = all ones, remainder = original dividend (no sign processing).
- END: ready_o=1, result_o holds; stays until start_i=0, then → IDLE (result_o, ready_o return to 0).
- annul_i=1 in BYZERO/ON/END → IDLE next edge; no ready_o pulse; outputs 0.
- Most-negative / −1 (signed): quotient = most-negative value (wraps), remainder = 0; no exception raised.
- busy_o = state is BYZERO or ON. ready_o and busy_o never both 1.
- start_i with annul_i=1 in IDLE: ignored.

## Timing
- Reset: state IDLE, counter 0, result_o 0, ready_o 0, busy_o 0, div_zero_o 0. Reset overrides all inputs including mid-division; no partial result emitted.
- Edge 0 = start accepted in IDLE. Normal: busy_o high cycles 1..WIDTH; ready_o first high after edge WIDTH+1 (latency WIDTH+1 edges).
- Divide-by-zero: busy_o high after edge 1 only; ready_o high after edge 2.
- All outputs registered/decoded from state only; no combinational path input → output.
- Back-to-back: after END→IDLE, new start accepted on the following edge (minimum one IDLE cycle between divisions).
- Operand changes after edge 0 have no effect.

## Configuration
- DIV_ZERO_FLAG_EN defined: div_zero_o port present; set on entry to BYZERO, held through END, cleared on return to IDLE, annul or reset.
- Not defined: port absent; divide-by-zero still produces quotient all ones / remainder = dividend with no indication.

## Test plan
- WIDTH=32, unsigned 100 / 7 → after 33 edges ready_o=1, result_o = {32'd2, 32'd14}; busy_o high exactly 32 cycles.
- Signed −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); signed 7 / −2 → quotient −3, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned same → quotient 0, remainder 0x80000000... (0x80000000/0xFFFFFFFF = 0 rem 0x80000000).
- 0x1234 / 0 → ready_o after 2 edges, result_o = {32'h1234, 32'hFFFFFFFF}, div_zero_o=1 (with macro).
- annul_i pulse at cycle 10 of a division → IDLE next edge, ready_o never asserts; new start 1 cycle later completes correctly. Repeat with rst instead of annul.
- WIDTH=8 build: 200 / 3 → ready_o after 9 edges, result_o = {8'd2, 8'd66}; hold start_i 5 extra cycles → result stable, then drops 1 cycle after start_i falls.
